// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port fixed-priority arbiter with starvation guard for data_memory
// Optional grant statistics: define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  p0_gnt_cnt,
  output logic [CNT_W-1:0]  p1_gnt_cnt
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [DATA_W-1:0]   r_p0_rdata;
  logic [DATA_W-1:0]   r_p1_rdata;
  logic                w_grant;
  logic                w_grant_p1;
  logic                w_mem_we;
  logic                w_p0_done;
  logic                w_p1_done;
  logic                w_capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_p1 = 1'b0;
    w_mem_we   = 1'b0;
    w_p0_done  = 1'b0;
    w_p1_done  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          w_grant    = 1'b1;
          // p1 wins when alone, or when p0 has already beaten it MAX_WAIT times in a row
          w_grant_p1 = p1_req && (!p0_req || (r_wait_cnt == MAX_WAIT_V));
          w_next     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_mem_we  = r_we;
        w_capture = !r_we;
        w_next    = S_DONE;
      end
      S_DONE: begin
        w_p0_done = !r_owner;
        w_p1_done = r_owner;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_p1;
        r_we    <= w_grant_p1 ? p1_we    : p0_we;
        r_addr  <= w_grant_p1 ? p1_addr  : p0_addr;
        r_wdata <= w_grant_p1 ? p1_wdata : p0_wdata;
        if (w_grant_p1)  r_wait_cnt <= '0;
        else if (p1_req) r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_capture) begin
        if (r_owner) r_p1_rdata <= mem_rdata;
        else         r_p0_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_p0_gnt_cnt;
  logic [CNT_W-1:0] r_p1_gnt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p0_gnt_cnt <= '0;
      r_p1_gnt_cnt <= '0;
    end else begin
      if (w_p0_done) r_p0_gnt_cnt <= r_p0_gnt_cnt + 1'b1;
      if (w_p1_done) r_p1_gnt_cnt <= r_p1_gnt_cnt + 1'b1;
    end
  end

  assign p0_gnt_cnt = r_p0_gnt_cnt;
  assign p1_gnt_cnt = r_p1_gnt_cnt;
`endif

  // latched address/data only change on entry to ACCESS, so they hold between accesses
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = w_mem_we;
  assign p0_done   = w_p0_done;
  assign p1_done   = w_p1_done;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_done, p1_done;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;
  logic [1:0]  p0_gnt_cnt, p1_gnt_cnt;

  logic [15:0] mem [0:255];
  logic        tb_wr;
  logic [7:0]  tb_waddr;
  logic [15:0] tb_wdata;

  int checks = 0;
  int errors = 0;
  int grants [0:9];
  int n_grants;
  int n_done;
  int exp_grant;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[7:0]] <= mem_wdata;
    else if (tb_wr) mem[tb_waddr]      <= tb_wdata;
  end

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
    , .p0_gnt_cnt(p0_gnt_cnt), .p1_gnt_cnt(p1_gnt_cnt)
`endif
  );

`ifndef DMEM_ARB_STATS_EN
  assign p0_gnt_cnt = 2'd0;
  assign p1_gnt_cnt = 2'd0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    tb_wr = 1'b1; tb_waddr = a; tb_wdata = d;
    @(negedge clk);
    tb_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tb_wr = 1'b0; tb_waddr = '0; tb_wdata = '0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    @(negedge clk);
    preload(8'h20, 16'h1234);
    preload(8'h30, 16'h5555);

    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_p0_done", p0_done, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // p0 write 0x0010 = 0xBEEF
    p0_req = 1; p0_we = 1; p0_addr = 16'h0010; p0_wdata = 16'hBEEF;
    check("t1_idle_we", mem_we, 0);
    @(negedge clk);
    check("t1_acc_busy", busy, 1);
    check("t1_acc_we", mem_we, 1);
    check("t1_acc_addr", mem_addr, 16'h0010);
    check("t1_acc_wdata", mem_wdata, 16'hBEEF);
    check("t1_acc_done", p0_done, 0);
    @(negedge clk);
    check("t1_done", p0_done, 1);
    check("t1_done_we", mem_we, 0);
    check("t1_mem", mem[8'h10], 16'hBEEF);
    p0_req = 0;
    @(negedge clk);
    check("t1_idle_done", p0_done, 0);
    check("t1_idle_busy", busy, 0);

    // p0 read back 0x0010
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    @(negedge clk);
    check("t1r_acc_we", mem_we, 0);
    @(negedge clk);
    check("t1r_done", p0_done, 1);
    check("t1r_rdata", p0_rdata, 16'hBEEF);
    p0_req = 0;
    @(negedge clk);
    check("t1r_hold_rdata", p0_rdata, 16'hBEEF);

    // p1 read of preloaded 0x0020
    p1_req = 1; p1_we = 0; p1_addr = 16'h0020;
    @(negedge clk);
    check("t2_acc_addr", mem_addr, 16'h0020);
    @(negedge clk);
    check("t2_done", p1_done, 1);
    check("t2_rdata", p1_rdata, 16'h1234);
    check("t2_p0_done", p0_done, 0);
    check("t2_p0_rdata", p0_rdata, 16'hBEEF);
    p1_req = 0;
    @(negedge clk);
    check("t2_hold_addr", mem_addr, 16'h0020);
    check("t2_idle_we", mem_we, 0);

    // both ports request continuously; starvation guard at MAX_WAIT=4
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    p1_req = 1; p1_we = 0; p1_addr = 16'h0020;
    n_grants = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (p0_done && n_grants < 10) begin grants[n_grants] = 0; n_grants++; end
      if (p1_done && n_grants < 10) begin grants[n_grants] = 1; n_grants++; end
    end
    p0_req = 0; p1_req = 0;
    check("t3_grant_count", n_grants, 10);
    for (int g = 0; g < 10; g++) begin
      exp_grant = (g == 4 || g == 9) ? 1 : 0;
      check($sformatf("t3_grant%0d", g), grants[g], exp_grant);
    end
    @(negedge clk);
    check("t3_idle_busy", busy, 0);

    // async reset during ACCESS of a p0 write to 0x0030
    p0_req = 1; p0_we = 1; p0_addr = 16'h0030; p0_wdata = 16'hAAAA;
    @(negedge clk);
    check("t4_acc_we", mem_we, 1);
    rst = 1'b1;
    #1;
    check("t4_rst_busy", busy, 0);
    check("t4_rst_we", mem_we, 0);
    p0_req = 0;
    n_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (p0_done) n_done++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (p0_done) n_done++;
    check("t4_no_done", n_done, 0);
    check("t4_mem_unchanged", mem[8'h30], 16'h5555);

    // p0 changes addr/we and drops req during ACCESS
    p0_req = 1; p0_we = 0; p0_addr = 16'h0010;
    @(negedge clk);
    p0_req = 0; p0_we = 1; p0_addr = 16'h0020; p0_wdata = 16'h0000;
    #1;
    check("t5_acc_addr", mem_addr, 16'h0010);
    check("t5_acc_we", mem_we, 0);
    @(negedge clk);
    check("t5_done", p0_done, 1);
    check("t5_rdata", p0_rdata, 16'hBEEF);
    @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_mem20", mem[8'h20], 16'h1234);

`ifdef DMEM_ARB_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_p1cnt", p1_gnt_cnt, 0);
    for (int t = 0; t < 5; t++) begin
      p1_req = 1; p1_we = 0; p1_addr = 16'h0020;
      @(negedge clk);
      @(negedge clk);
      p1_req = 0;
      @(negedge clk);
    end
    check("t6_p1_cnt", p1_gnt_cnt, 1);
    check("t6_p0_cnt", p0_gnt_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
